// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundle between two memory requesters, the arbiter and a synchronous-read memory.
//   Requester side : req0/1, lock0/1, we0/1, addr0/1, wdata0/1 -> gnt0/1, rvalid0/1, rdata
//   Memory side    : memAddr, memWrData, memWe -> memRdData
//   Status         : busy
//   modport slave  : the arbiter's view
//   modport master : the view of the requesters and the memory (testbench / system side)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req0, req1;
  logic              lock0, lock1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWrData;
  logic              memWe;
  logic [DATA_W-1:0] memRdData;
  logic              busy;

  modport slave (
    input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, memRdData,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, memAddr, memWrData, memWe, busy
  );

  modport master (
    output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1, memRdData,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, memAddr, memWrData, memWe, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous-read memory port between requester 0 (CPU) and
//   requester 1 (peripheral master). One outstanding access, round-robin on ties,
//   bounded lock chaining of back-to-back accesses by the current owner.
// Ports
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : mem_port_arbiter_if.slave (requester handshakes, memory port, busy)
// Parameters
//   ADDR_W, DATA_W : address / data widths (must match the interface)
//   LOCK_MAX       : max consecutive chained accesses per owner, 1..15
// Build option
//   MEM_ARB_CPU_PRIORITY_EN : when defined, requester 0 always wins a tie in IDLE.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no access in flight; arbitrate between pending requests
// ISSUE  | drive owner's address/data/we to memory, pulse gnt[owner]
// RDWAIT | read data returning from memory, pulse rvalid[owner]
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT_MAX = 4'(LOCK_MAX);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [3:0]  lock_cnt_q, lock_cnt_d;

  logic              req_own, lock_own, we_own;
  logic [ADDR_W-1:0] addr_own;
  logic [DATA_W-1:0] wdata_own;

  assign req_own   = owner_q ? bus.req1   : bus.req0;
  assign lock_own  = owner_q ? bus.lock1  : bus.lock0;
  assign we_own    = owner_q ? bus.we1    : bus.we0;
  assign addr_own  = owner_q ? bus.addr1  : bus.addr0;
  assign wdata_own = owner_q ? bus.wdata1 : bus.wdata0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      lock_cnt_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      lock_cnt_q   <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    lock_cnt_d   = lock_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        lock_cnt_d = 4'd0;
        if (bus.req0 && bus.req1) begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
          owner_d = 1'b0;
`else
          owner_d = ~last_owner_q;
`endif
          state_d = S_ISSUE;
        end else if (bus.req0) begin
          owner_d = 1'b0;
          state_d = S_ISSUE;
        end else if (bus.req1) begin
          owner_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        last_owner_d = owner_q;
        lock_cnt_d   = lock_cnt_q + 4'd1;
        if (!we_own) begin
          state_d = S_RDWAIT;
        // A write completes here, so the chain test uses the count including this access.
        end else if (req_own && lock_own && ((lock_cnt_q + 4'd1) < LOCK_CNT_MAX)) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RDWAIT: begin
        if (req_own && lock_own && (lock_cnt_q < LOCK_CNT_MAX)) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode only registered state/owner, so they drop to zero as soon as reset asserts.
  logic in_issue, in_rdwait;
  assign in_issue  = (state_q == S_ISSUE);
  assign in_rdwait = (state_q == S_RDWAIT);

  assign bus.gnt0      = in_issue  && !owner_q;
  assign bus.gnt1      = in_issue  &&  owner_q;
  assign bus.rvalid0   = in_rdwait && !owner_q;
  assign bus.rvalid1   = in_rdwait &&  owner_q;
  assign bus.memWe     = in_issue  && we_own;
  assign bus.memAddr   = in_issue  ? addr_own  : '0;
  assign bus.memWrData = in_issue  ? wdata_own : '0;
  assign bus.rdata     = in_rdwait ? bus.memRdData : '0;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  logic [15:0] mem [0:1023];

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .LOCK_MAX(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory model: data valid the cycle after the address.
  always @(posedge clk) begin
    if (bus.memWe) mem[bus.memAddr[9:0]] <= bus.memWrData;
    bus.memRdData <= mem[bus.memAddr[9:0]];
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin tests_failed++; $display("FAIL reset_gnt: got %b%b want 00", bus.gnt0, bus.gnt1); end
    tests_run++; if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin tests_failed++; $display("FAIL reset_rvalid: got %b%b want 00", bus.rvalid0, bus.rvalid1); end
    tests_run++; if (bus.memWe !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_we_busy: got %b%b want 00", bus.memWe, bus.busy); end
    tests_run++; if (bus.memAddr !== 16'h0 || bus.memWrData !== 16'h0) begin tests_failed++; $display("FAIL reset_addr_data: got %h %h want 0000 0000", bus.memAddr, bus.memWrData); end
    reset = 1'b1;
  endtask

  task automatic test_cpu_read();
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
    @(negedge clk);
    tests_run++; if (bus.busy !== 1'b0 || bus.gnt0 !== 1'b0) begin tests_failed++; $display("FAIL cpu_read_idle: busy=%b gnt0=%b want 0 0", bus.busy, bus.gnt0); end
    @(negedge clk);
    tests_run++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin tests_failed++; $display("FAIL cpu_read_gnt: gnt0=%b gnt1=%b want 1 0", bus.gnt0, bus.gnt1); end
    tests_run++; if (bus.memAddr !== 16'h0010 || bus.memWe !== 1'b0) begin tests_failed++; $display("FAIL cpu_read_addr: addr=%h we=%b want 0010 0", bus.memAddr, bus.memWe); end
    tests_run++; if (bus.busy !== 1'b1 || bus.rvalid0 !== 1'b0) begin tests_failed++; $display("FAIL cpu_read_issue_busy: busy=%b rvalid0=%b want 1 0", bus.busy, bus.rvalid0); end
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.rvalid0 !== 1'b1 || bus.rvalid1 !== 1'b0) begin tests_failed++; $display("FAIL cpu_read_rvalid: rvalid0=%b rvalid1=%b want 1 0", bus.rvalid0, bus.rvalid1); end
    tests_run++; if (bus.rdata !== 16'hBEEF) begin tests_failed++; $display("FAIL cpu_read_rdata: got %h want beef", bus.rdata); end
    tests_run++; if (bus.busy !== 1'b1 || bus.gnt0 !== 1'b0) begin tests_failed++; $display("FAIL cpu_read_rdwait: busy=%b gnt0=%b want 1 0", bus.busy, bus.gnt0); end
    @(negedge clk);
    tests_run++; if (bus.busy !== 1'b0 || bus.rvalid0 !== 1'b0) begin tests_failed++; $display("FAIL cpu_read_done: busy=%b rvalid0=%b want 0 0", bus.busy, bus.rvalid0); end
  endtask

  task automatic test_tie();
    logic seq [0:3];
    int   n_gnt;
    logic last_gnt;
    n_gnt = 0;
    last_gnt = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0020;
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.gnt0 || bus.gnt1) begin
        if (n_gnt < 4) seq[n_gnt] = bus.gnt1;
        n_gnt++;
        last_gnt = bus.gnt1;
      end
      if (bus.rvalid0 || bus.rvalid1) begin
        tests_run++; if (bus.rvalid1 !== last_gnt || bus.rvalid0 !== ~last_gnt) begin tests_failed++; $display("FAIL tie_rvalid_owner: rvalid0=%b rvalid1=%b last_gnt=%0d", bus.rvalid0, bus.rvalid1, last_gnt); end
        tests_run++; if (bus.rdata !== (last_gnt ? 16'hCAFE : 16'hBEEF)) begin tests_failed++; $display("FAIL tie_rdata: got %h for requester %0d", bus.rdata, last_gnt); end
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    tests_run++; if (n_gnt !== 4) begin tests_failed++; $display("FAIL tie_gnt_count: got %0d want 4", n_gnt); end
    else begin
      tests_run++; if (seq[0] !== 1'b0 || seq[1] !== 1'b1 || seq[2] !== 1'b0 || seq[3] !== 1'b1) begin tests_failed++; $display("FAIL tie_order: got %0d%0d%0d%0d want 0101", seq[0], seq[1], seq[2], seq[3]); end
    end
    @(negedge clk);
  endtask

  task automatic test_write();
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 16'h0200; bus.wdata1 = 16'h1234;
    @(negedge clk);
    tests_run++; if (bus.gnt1 !== 1'b1 || bus.memWe !== 1'b1) begin tests_failed++; $display("FAIL write_gnt_we: gnt1=%b memWe=%b want 1 1", bus.gnt1, bus.memWe); end
    tests_run++; if (bus.memAddr !== 16'h0200 || bus.memWrData !== 16'h1234) begin tests_failed++; $display("FAIL write_addr_data: got %h %h want 0200 1234", bus.memAddr, bus.memWrData); end
    tests_run++; if (bus.rvalid1 !== 1'b0 || bus.rvalid0 !== 1'b0) begin tests_failed++; $display("FAIL write_issue_rvalid: got %b%b want 00", bus.rvalid0, bus.rvalid1); end
    bus.req1 = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.rvalid1 !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL write_done: rvalid1=%b busy=%b want 0 0", bus.rvalid1, bus.busy); end
    bus.req1 = 1'b1; bus.we1 = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.gnt1 !== 1'b1 || bus.memWe !== 1'b0) begin tests_failed++; $display("FAIL write_readback_gnt: gnt1=%b memWe=%b want 1 0", bus.gnt1, bus.memWe); end
    @(posedge clk); #1;
    bus.req1 = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.rvalid1 !== 1'b1 || bus.rdata !== 16'h1234) begin tests_failed++; $display("FAIL write_readback: rvalid1=%b rdata=%h want 1 1234", bus.rvalid1, bus.rdata); end
    @(negedge clk);
  endtask

  task automatic test_lock();
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0030;
    bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0000; bus.wdata0 = 16'h0100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++; if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.memAddr !== 16'(k)) begin tests_failed++; $display("FAIL lock_chain_%0d: gnt0=%b gnt1=%b addr=%h want 1 0 %h", k, bus.gnt0, bus.gnt1, bus.memAddr, 16'(k)); end
      bus.addr0 = 16'(k + 1); bus.wdata0 = 16'h0100 + 16'(k + 1);
    end
    @(negedge clk);
    tests_run++; if (bus.busy !== 1'b0 || bus.gnt0 !== 1'b0) begin tests_failed++; $display("FAIL lock_forced_idle: busy=%b gnt0=%b want 0 0", bus.busy, bus.gnt0); end
    @(negedge clk);
    tests_run++; if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin tests_failed++; $display("FAIL lock_other_wins: gnt0=%b gnt1=%b want 0 1", bus.gnt0, bus.gnt1); end
    @(posedge clk); #1;
    bus.req1 = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.rvalid1 !== 1'b1 || bus.rdata !== 16'h3030) begin tests_failed++; $display("FAIL lock_other_read: rvalid1=%b rdata=%h want 1 3030", bus.rvalid1, bus.rdata); end
    @(negedge clk);
    @(negedge clk);
    tests_run++; if (bus.gnt0 !== 1'b1 || bus.memAddr !== 16'h0004 || bus.memWrData !== 16'h0104) begin tests_failed++; $display("FAIL lock_fifth_write: gnt0=%b addr=%h data=%h want 1 0004 0104", bus.gnt0, bus.memAddr, bus.memWrData); end
    bus.req0 = 1'b0; bus.lock0 = 1'b0;
    @(negedge clk);
    tests_run++; if (mem[3] !== 16'h0103 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL lock_mem_contents: mem[3]=%h busy=%b want 0103 0", mem[3], bus.busy); end
    bus.we0 = 1'b0;
  endtask

  task automatic test_chained_read();
    bus.req0 = 1'b1; bus.lock0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
    @(negedge clk);
    tests_run++; if (bus.gnt0 !== 1'b1 || bus.memAddr !== 16'h0010) begin tests_failed++; $display("FAIL chain_rd_gnt_a: gnt0=%b addr=%h want 1 0010", bus.gnt0, bus.memAddr); end
    @(negedge clk);
    tests_run++; if (bus.rvalid0 !== 1'b1 || bus.rdata !== 16'hBEEF) begin tests_failed++; $display("FAIL chain_rd_data_a: rvalid0=%b rdata=%h want 1 beef", bus.rvalid0, bus.rdata); end
    bus.addr0 = 16'h0020;
    @(negedge clk);
    tests_run++; if (bus.gnt0 !== 1'b1 || bus.memAddr !== 16'h0020) begin tests_failed++; $display("FAIL chain_rd_gnt_b: gnt0=%b addr=%h want 1 0020", bus.gnt0, bus.memAddr); end
    @(negedge clk);
    tests_run++; if (bus.rvalid0 !== 1'b1 || bus.rdata !== 16'hCAFE) begin tests_failed++; $display("FAIL chain_rd_data_b: rvalid0=%b rdata=%h want 1 cafe", bus.rvalid0, bus.rdata); end
    bus.req0 = 1'b0; bus.lock0 = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL chain_rd_done: busy=%b want 0", bus.busy); end
  endtask

  task automatic test_reset_mid_read();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010;
    @(negedge clk);
    @(posedge clk); #1;
    tests_run++; if (bus.rvalid0 !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_in_rdwait: rvalid0=%b want 1", bus.rvalid0); end
    reset = 1'b0;
    #1;
    tests_run++; if (bus.rvalid0 !== 1'b0 || bus.busy !== 1'b0 || bus.rdata !== 16'h0) begin tests_failed++; $display("FAIL rst_mid_clear: rvalid0=%b busy=%b rdata=%h want 0 0 0000", bus.rvalid0, bus.busy, bus.rdata); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.gnt0 !== 1'b1 || bus.memAddr !== 16'h0010) begin tests_failed++; $display("FAIL rst_mid_regrant: gnt0=%b addr=%h want 1 0010", bus.gnt0, bus.memAddr); end
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.rvalid0 !== 1'b1 || bus.rdata !== 16'hBEEF) begin tests_failed++; $display("FAIL rst_mid_reread: rvalid0=%b rdata=%h want 1 beef", bus.rvalid0, bus.rdata); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    int g0;
    int g1;
    g0 = 0;
    g1 = 0;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0010; bus.lock0 = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0020; bus.lock1 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.gnt0) g0++;
      if (bus.gnt1) g1++;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
`ifdef MEM_ARB_CPU_PRIORITY_EN
    tests_run++; if (g1 !== 0 || g0 !== 10) begin tests_failed++; $display("FAIL priority_counts: gnt0=%0d gnt1=%0d want 10 0", g0, g1); end
`else
    tests_run++; if (g0 !== 5 || g1 !== 5) begin tests_failed++; $display("FAIL round_robin_counts: gnt0=%0d gnt1=%0d want 5 5", g0, g1); end
`endif
    @(negedge clk);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[16'h0010] = 16'hBEEF;
    mem[16'h0020] = 16'hCAFE;
    mem[16'h0030] = 16'h3030;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.lock0 = 1'b0; bus.lock1 = 1'b0;
    bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 16'h0; bus.addr1 = 16'h0; bus.wdata0 = 16'h0; bus.wdata1 = 16'h0;

    test_reset();
    test_cpu_read();
    test_tie();
    test_write();
    test_lock();
    test_chained_read();
    test_reset_mid_read();
    test_contention();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
